// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word-aligned IMEM reads from the current PC and tracks in-order responses.
// Buffers fetched words with their PCs for decode, and drops stale responses after a redirect.
module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        IF_RST,
    input  logic [31:0] PC_COUNT,
    output logic        PC_WRITE,
    output logic [31:0] PC_SEQ,
    input  logic        FLUSH,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        IR_VALID,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    input  logic        IR_READY
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] outstanding, outstanding_next;
    logic [CW-1:0] drop_cnt, drop_next;
    logic [CW-1:0] fifo_count, fifo_count_next;
    logic [CW-1:0] stale;
    logic [CW:0]   in_use;

    logic [31:0]   pcq_mem  [FIFO_DEPTH];
    logic [31:0]   ir_mem   [FIFO_DEPTH];
    logic [31:0]   irpc_mem [FIFO_DEPTH];
    logic [PW-1:0] pcq_rd, pcq_wr;
    logic [PW-1:0] fifo_rd, fifo_wr;

    logic grant;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credit counts both in-flight and buffered words, so a response always finds FIFO space.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign IMEM_REQ  = !IF_RST && (state == RUN) && !FLUSH && (in_use < DEPTH_W);
    assign IMEM_ADDR = {PC_COUNT[31:2], 2'b00};
    assign grant     = IMEM_REQ && IMEM_GNT;
    assign PC_WRITE  = !IF_RST && (grant || FLUSH);
    assign PC_SEQ    = PC_COUNT + 32'd4;

    assign IR_VALID  = (fifo_count != '0);
    assign IR        = IR_VALID ? ir_mem[fifo_rd]   : '0;
    assign IR_PC     = IR_VALID ? irpc_mem[fifo_rd] : '0;

    assign stale     = outstanding - CW'(IMEM_RVALID);
    assign push      = IMEM_RVALID && (state == RUN) && !FLUSH;
    assign pop       = IR_VALID && IR_READY;

    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        case (state)
            RUN: begin
                if (FLUSH && (stale != '0)) begin
                    state_next = DRAIN;
                    drop_next  = stale;
                end
            end
            DRAIN: begin
                if (FLUSH) begin
                    drop_next = stale;
                    if (stale == '0) state_next = RUN;
                end else if (IMEM_RVALID) begin
                    drop_next = drop_cnt - CW'(1);
                    if (drop_cnt == CW'(1)) state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        outstanding_next = outstanding + CW'(grant) - CW'(IMEM_RVALID);
        fifo_count_next  = fifo_count + CW'(push) - CW'(pop);
        if (FLUSH) fifo_count_next = '0;
    end

    always_ff @(posedge CLK) begin
        if (IF_RST) begin
            state       <= RUN;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            fifo_count  <= fifo_count_next;
            if (grant)       pcq_wr <= next_ptr(pcq_wr);
            if (IMEM_RVALID) pcq_rd <= next_ptr(pcq_rd);
            if (FLUSH) begin
                fifo_rd <= '0;
                fifo_wr <= '0;
            end else begin
                if (push) fifo_wr <= next_ptr(fifo_wr);
                if (pop)  fifo_rd <= next_ptr(fifo_rd);
            end
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers and counts above.
    always_ff @(posedge CLK) begin
        if (grant) pcq_mem[pcq_wr] <= PC_COUNT;
        if (push) begin
            ir_mem[fifo_wr]   <= IMEM_RDATA;
            irpc_mem[fifo_wr] <= pcq_mem[pcq_rd];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: emulates the PC register and an in-order IMEM, and checks every
// cycle against a queue-based reference model of outstanding PCs and buffered instructions.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        CLK = 1'b0;
    logic        IF_RST, FLUSH, IMEM_GNT, IMEM_RVALID, IR_READY;
    logic [31:0] PC_COUNT, IMEM_RDATA;
    logic        PC_WRITE, IMEM_REQ, IR_VALID;
    logic [31:0] PC_SEQ, IMEM_ADDR, IR, IR_PC;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .IF_RST(IF_RST), .PC_COUNT(PC_COUNT), .PC_WRITE(PC_WRITE), .PC_SEQ(PC_SEQ),
        .FLUSH(FLUSH), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .IR_VALID(IR_VALID), .IR(IR),
        .IR_PC(IR_PC), .IR_READY(IR_READY)
    );

    typedef struct { logic [31:0] ir; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int due; } rsp_t;

    logic [31:0] pcq[$];      // PCs of granted, unanswered requests
    ent_t        fifo_q[$];   // instructions waiting for decode
    rsp_t        mem_q[$];    // memory-side pending responses
    int          drop;        // stale responses still to be thrown away
    int          cyc;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] pc_reg, flush_target;
    int          lat_min, lat_max;
    bit          const_data;
    logic        exp_req, exp_pcw, exp_valid;
    logic [31:0] exp_addr, exp_seq, exp_ir, exp_irpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (const_data) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Drive memory response and PC, then derive what the fetch unit should show this cycle.
    task automatic setup_cycle();
        if (!IF_RST && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = mem_word(mem_q[0].addr);
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = $urandom;
        end
        PC_COUNT  = pc_reg;
        exp_req   = !IF_RST && drop == 0 && !FLUSH && (pcq.size() + fifo_q.size() < int'(DEPTH));
        exp_pcw   = !IF_RST && ((exp_req && IMEM_GNT) || FLUSH);
        exp_addr  = pc_reg & 32'hFFFF_FFFC;
        exp_seq   = pc_reg + 32'd4;
        exp_valid = fifo_q.size() > 0;
        exp_ir    = exp_valid ? fifo_q[0].ir : 32'h0;
        exp_irpc  = exp_valid ? fifo_q[0].pc : 32'h0;
        #1;
    endtask

    task automatic finish_cycle();
        bit          grant, rv;
        int          stale;
        logic [31:0] rpc, rdata;
        grant = exp_req && IMEM_GNT;
        rv    = IMEM_RVALID;
        rdata = IMEM_RDATA;
        @(posedge CLK);
        if (IF_RST) begin
            pcq.delete(); fifo_q.delete(); mem_q.delete();
            drop = 0;
        end else begin
            stale = pcq.size() - int'(rv);
            if (exp_valid && IR_READY) void'(fifo_q.pop_front());
            if (rv) begin
                rpc = pcq.pop_front();
                void'(mem_q.pop_front());
                if (!FLUSH) begin
                    if (drop > 0) drop--;
                    else fifo_q.push_back('{ir: rdata, pc: rpc});
                end
            end
            if (FLUSH) begin
                fifo_q.delete();
                drop = stale;
            end
            if (grant) begin
                pcq.push_back(pc_reg);
                mem_q.push_back('{addr: pc_reg & 32'hFFFF_FFFC,
                                  due: cyc + int'($urandom_range(lat_max, lat_min))});
            end
            if (FLUSH) pc_reg = flush_target;
            else if (grant) pc_reg = pc_reg + 32'd4;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        IF_RST = 1'b1; FLUSH = 1'b0; IMEM_GNT = 1'b0; IR_READY = 1'b0;
        setup_cycle();
        finish_cycle();
        IF_RST = 1'b0;
        pc_reg = start_pc;
    endtask

    task automatic test_reset();
        pc_reg = 32'h0; IF_RST = 1'b1; FLUSH = 1'b1; IMEM_GNT = 1'b1; IR_READY = 1'b0;
        flush_target = 32'h0;
        for (int i = 0; i < 2; i++) begin
            setup_cycle();
            checks++;
            if ({IMEM_REQ, PC_WRITE} !== 2'b00)
                $display("FAIL reset_req_pcw cyc=%0d got %b%b want 00", cyc, IMEM_REQ, PC_WRITE);
            else passes++;
            finish_cycle();
        end
        IF_RST = 1'b0; FLUSH = 1'b0; IMEM_GNT = 1'b0;
        setup_cycle();
        checks++;
        if ({IR_VALID, IR, IR_PC} !== 65'h0)
            $display("FAIL reset_ir got valid=%b ir=%h pc=%h want 0/0/0", IR_VALID, IR, IR_PC);
        else passes++;
        checks++;
        if (IMEM_REQ !== 1'b1) $display("FAIL reset_first_req got %b want 1", IMEM_REQ);
        else passes++;
        finish_cycle();
    endtask

    task automatic test_stream();
        do_reset(32'h0);
        const_data = 1'b1; lat_min = 1; lat_max = 1;
        IMEM_GNT = 1'b1; IR_READY = 1'b1;
        for (int k = 0; k < 14; k++) begin
            setup_cycle();
            checks++;
            if ({IMEM_REQ, PC_WRITE, IR_VALID} !== {exp_req, exp_pcw, exp_valid})
                $display("FAIL stream_ctl k=%0d req/pcw/valid got %b%b%b want %b%b%b", k,
                         IMEM_REQ, PC_WRITE, IR_VALID, exp_req, exp_pcw, exp_valid);
            else passes++;
            if (exp_req) begin
                checks++;
                if (IMEM_ADDR !== exp_addr)
                    $display("FAIL stream_addr k=%0d got %h want %h", k, IMEM_ADDR, exp_addr);
                else passes++;
            end
            if (exp_valid) begin
                checks++;
                if ({IR, IR_PC} !== {exp_ir, exp_irpc})
                    $display("FAIL stream_ir k=%0d got %h/%h want %h/%h", k, IR, IR_PC, exp_ir, exp_irpc);
                else passes++;
            end
            if (k == 2) begin
                checks++;
                if ({IR_VALID, IR, IR_PC} !== {1'b1, 32'h13, 32'h0})
                    $display("FAIL stream_first_ir got %b/%h/%h want 1/00000013/00000000",
                             IR_VALID, IR, IR_PC);
                else passes++;
            end
            finish_cycle();
        end
        const_data = 1'b0;
    endtask

    task automatic test_backpressure();
        int writes;
        do_reset(32'h80);
        lat_min = 1; lat_max = 1; IMEM_GNT = 1'b1; IR_READY = 1'b0;
        writes = 0;
        for (int k = 0; k < 6; k++) begin
            setup_cycle();
            writes += int'(PC_WRITE);
            checks++;
            if ({IMEM_REQ, IR_VALID} !== {exp_req, exp_valid})
                $display("FAIL bp_ctl k=%0d req/valid got %b%b want %b%b", k, IMEM_REQ, IR_VALID,
                         exp_req, exp_valid);
            else passes++;
            finish_cycle();
        end
        checks++;
        if (writes != int'(DEPTH)) $display("FAIL bp_grants got %0d want %0d", writes, DEPTH);
        else passes++;
        IR_READY = 1'b1;
        setup_cycle();
        checks++;
        if ({IMEM_REQ, IR_VALID, IR_PC} !== {1'b0, 1'b1, 32'h80})
            $display("FAIL bp_pop_cycle req/valid/pc got %b/%b/%h want 0/1/00000080",
                     IMEM_REQ, IR_VALID, IR_PC);
        else passes++;
        finish_cycle();
        IR_READY = 1'b0;
        setup_cycle();
        checks++;
        if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 32'h88})
            $display("FAIL bp_reissue req/addr got %b/%h want 1/00000088", IMEM_REQ, IMEM_ADDR);
        else passes++;
        finish_cycle();
        IR_READY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            setup_cycle();
            checks++;
            if ({IMEM_REQ, PC_WRITE, IR_VALID, IR_PC} !== {exp_req, exp_pcw, exp_valid, exp_irpc})
                $display("FAIL bp_drain k=%0d got %b%b%b/%h want %b%b%b/%h", k, IMEM_REQ, PC_WRITE,
                         IR_VALID, IR_PC, exp_req, exp_pcw, exp_valid, exp_irpc);
            else passes++;
            finish_cycle();
        end
    endtask

    task automatic test_gnt_stall();
        do_reset(32'h40);
        lat_min = 1; lat_max = 2; IMEM_GNT = 1'b0; IR_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setup_cycle();
            checks++;
            if ({IMEM_REQ, IMEM_ADDR, PC_WRITE, IR_VALID} !== {1'b1, 32'h40, 1'b0, 1'b0})
                $display("FAIL stall k=%0d req/addr/pcw/valid got %b/%h/%b/%b want 1/00000040/0/0",
                         k, IMEM_REQ, IMEM_ADDR, PC_WRITE, IR_VALID);
            else passes++;
            finish_cycle();
        end
        IMEM_GNT = 1'b1;
        for (int k = 0; k < 8; k++) begin
            setup_cycle();
            checks++;
            if ({IMEM_REQ, PC_WRITE, IR_VALID, IR, IR_PC} !==
                {exp_req, exp_pcw, exp_valid, exp_ir, exp_irpc})
                $display("FAIL stall_resume k=%0d got %b%b%b %h/%h want %b%b%b %h/%h", k, IMEM_REQ,
                         PC_WRITE, IR_VALID, IR, IR_PC, exp_req, exp_pcw, exp_valid, exp_ir, exp_irpc);
            else passes++;
            finish_cycle();
        end
    endtask

    task automatic test_flush_drain();
        bit seen;
        do_reset(32'h10);
        lat_min = 3; lat_max = 3; IMEM_GNT = 1'b1; IR_READY = 1'b1;
        for (int k = 0; k < 2; k++) begin setup_cycle(); finish_cycle(); end
        FLUSH = 1'b1; flush_target = 32'h100;
        setup_cycle();
        checks++;
        if ({PC_WRITE, IMEM_REQ} !== 2'b10)
            $display("FAIL flush_cycle pcw/req got %b%b want 10", PC_WRITE, IMEM_REQ);
        else passes++;
        finish_cycle();
        FLUSH = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            setup_cycle();
            checks++;
            if ({IMEM_REQ, PC_WRITE, IR_VALID} !== {exp_req, exp_pcw, exp_valid})
                $display("FAIL drain_ctl k=%0d got %b%b%b want %b%b%b", k, IMEM_REQ, PC_WRITE,
                         IR_VALID, exp_req, exp_pcw, exp_valid);
            else passes++;
            if (k < 2) begin
                checks++;
                if (IMEM_REQ !== 1'b0) $display("FAIL drain_req k=%0d got %b want 0", k, IMEM_REQ);
                else passes++;
            end
            if (k == 2) begin
                checks++;
                if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 32'h100})
                    $display("FAIL drain_redirect got %b/%h want 1/00000100", IMEM_REQ, IMEM_ADDR);
                else passes++;
            end
            if (IR_VALID === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (IR_PC !== 32'h100) $display("FAIL drain_first_ir got %h want 00000100", IR_PC);
                else passes++;
            end
            finish_cycle();
        end
        checks++;
        if (!seen) $display("FAIL drain_no_ir got IR_VALID never want 1 within 12 cycles");
        else passes++;
    endtask

    task automatic test_flush_rvalid();
        do_reset(32'h200);
        lat_min = 2; lat_max = 2; IMEM_GNT = 1'b1; IR_READY = 1'b1;
        for (int k = 0; k < 2; k++) begin setup_cycle(); finish_cycle(); end
        FLUSH = 1'b1; flush_target = 32'h300;
        setup_cycle();
        checks++;
        if ({IMEM_RVALID, PC_WRITE, IMEM_REQ} !== 3'b110)
            $display("FAIL frv_cycle rvalid/pcw/req got %b%b%b want 110", IMEM_RVALID, PC_WRITE,
                     IMEM_REQ);
        else passes++;
        finish_cycle();
        FLUSH = 1'b0;
        setup_cycle();
        checks++;
        if ({IMEM_REQ, IR_VALID} !== 2'b00)
            $display("FAIL frv_drop req/valid got %b%b want 00", IMEM_REQ, IR_VALID);
        else passes++;
        finish_cycle();
        setup_cycle();
        checks++;
        if ({IMEM_REQ, IMEM_ADDR, IR_VALID} !== {1'b1, 32'h300, 1'b0})
            $display("FAIL frv_resume req/addr/valid got %b/%h/%b want 1/00000300/0",
                     IMEM_REQ, IMEM_ADDR, IR_VALID);
        else passes++;
        finish_cycle();
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFC);
        IMEM_GNT = 1'b0;
        setup_cycle();
        checks++;
        if (PC_SEQ !== 32'h0) $display("FAIL wrap_seq got %h want 00000000", PC_SEQ);
        else passes++;
        finish_cycle();
        do_reset(32'h6);
        lat_min = 1; lat_max = 1; IMEM_GNT = 1'b1; IR_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setup_cycle();
            if (k == 0) begin
                checks++;
                if ({IMEM_ADDR, PC_SEQ} !== {32'h4, 32'hA})
                    $display("FAIL misalign_addr got %h/%h want 00000004/0000000a", IMEM_ADDR, PC_SEQ);
                else passes++;
            end
            if (k == 2) begin
                checks++;
                if ({IR_VALID, IR, IR_PC} !== {1'b1, mem_word(32'h4), 32'h6})
                    $display("FAIL misalign_ir got %b/%h/%h want 1/%h/00000006", IR_VALID, IR,
                             IR_PC, mem_word(32'h4));
                else passes++;
            end
            finish_cycle();
        end
    endtask

    task automatic test_random();
        do_reset($urandom & 32'h0000_FFFC);
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 800; i++) begin
            IF_RST       = (i >= 400 && i < 402);
            IMEM_GNT     = ($urandom_range(9, 0) < 7);
            IR_READY     = ($urandom_range(9, 0) < 6);
            FLUSH        = ($urandom_range(99, 0) < 5);
            flush_target = $urandom;
            setup_cycle();
            checks++;
            if ({IMEM_REQ, PC_WRITE, IR_VALID} !== {exp_req, exp_pcw, exp_valid})
                $display("FAIL rand_ctl i=%0d req/pcw/valid got %b%b%b want %b%b%b", i, IMEM_REQ,
                         PC_WRITE, IR_VALID, exp_req, exp_pcw, exp_valid);
            else passes++;
            checks++;
            if (PC_SEQ !== exp_seq) $display("FAIL rand_seq i=%0d got %h want %h", i, PC_SEQ, exp_seq);
            else passes++;
            if (exp_req) begin
                checks++;
                if (IMEM_ADDR !== exp_addr)
                    $display("FAIL rand_addr i=%0d got %h want %h", i, IMEM_ADDR, exp_addr);
                else passes++;
            end
            if (exp_valid) begin
                checks++;
                if ({IR, IR_PC} !== {exp_ir, exp_irpc})
                    $display("FAIL rand_ir i=%0d got %h/%h want %h/%h", i, IR, IR_PC, exp_ir, exp_irpc);
                else passes++;
            end
            finish_cycle();
        end
        IF_RST = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        IF_RST = 1'b1; FLUSH = 1'b0; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IR_READY = 1'b0;
        PC_COUNT = '0; IMEM_RDATA = '0; pc_reg = '0; flush_target = '0;
        drop = 0; cyc = 0; lat_min = 1; lat_max = 1; const_data = 1'b0;
        @(negedge CLK);
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_flush_drain();
        test_flush_rvalid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
